// File: rtl/voting_pkg.sv
`default_nettype none
// ============================================================================
// Module   : voting_pkg
// Purpose  : Shared types and constants for the ballot session controller and
//            the vote logger. Holds the session state encoding, the default
//            candidate count and the ballot counter width.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package voting_pkg;

  // Default number of candidate buttons / grant lines.
  localparam int NUM_CAND_DEF = 4;

  // Width of the accepted-ballot counter; the vote logger uses the same width.
  localparam int COUNT_W = 8;

  // Session states, explicitly encoded so the encoding is stable across tools.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_GRANT  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_LOCKED = 3'd4
  } session_state_t;

endpackage : voting_pkg
`default_nettype wire

// File: rtl/session_timer.sv
`default_nettype none
// ============================================================================
// Module   : session_timer
// Purpose  : Loadable down-counter shared by the ARMED timeout and the HOLD
//            confirmation interval. Stops at zero instead of wrapping.
// Ports    : clk       - system clock, rising edge
//            rst       - synchronous active-high reset (count -> 0)
//            i_load    - load i_load_val this cycle (wins over i_enable)
//            i_load_val- value loaded into the counter
//            i_enable  - decrement by one when non-zero
//            o_zero    - counter currently equals zero
// Revision : 1.0 - initial release
// ============================================================================
module session_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_enable,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule : session_timer
`default_nettype wire

// File: rtl/ballot_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ballot_session_ctrl
// Purpose  : Per-voter session sequencer. Arms one ballot per officer enable,
//            accepts exactly one single-button press per session and forwards
//            it as a one-cycle one-hot grant. Rejects simultaneous presses,
//            abandons idle ballots after a timeout and locks voting while
//            result mode is selected. All outputs are registered.
// Ports    : clk           - system clock, rising edge
//            reset         - synchronous active-high reset
//            mode          - 0 = voting, 1 = result display
//            voter_enable  - officer pulse that arms a ballot
//            vote_req      - one-cycle request pulses from the debouncers
//            vote_grant    - one-hot, one-cycle grant to the vote logger
//            ballot_armed  - high while a press is accepted
//            vote_accepted - one-cycle pulse coincident with vote_grant
//            conflict      - one-cycle pulse on a multi-button press
//            timeout       - one-cycle pulse when an armed ballot is abandoned
//            last_choice   - one-hot of the last accepted candidate
//            ballots_cast  - accepted-ballot count, saturating at 255
// Revision : 1.0 - initial release
// ============================================================================
module ballot_session_ctrl
  import voting_pkg::*;
#(
  parameter int NUM_CAND    = NUM_CAND_DEF,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CONFIRM_CYC = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                voter_enable,
  input  logic [NUM_CAND-1:0] vote_req,
  output logic [NUM_CAND-1:0] vote_grant,
  output logic                ballot_armed,
  output logic                vote_accepted,
  output logic                conflict,
  output logic                timeout,
  output logic [NUM_CAND-1:0] last_choice,
  output logic [COUNT_W-1:0]  ballots_cast
);

  localparam int c_TIMER_MAX = (TIMEOUT_CYC > CONFIRM_CYC) ? TIMEOUT_CYC : CONFIRM_CYC;
  localparam int c_TIMER_W   = $clog2(c_TIMER_MAX);
  localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LOAD = c_TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [c_TIMER_W-1:0] c_CONFIRM_LOAD = c_TIMER_W'(CONFIRM_CYC - 1);

  session_state_t r_state;
  session_state_t w_state_nxt;

  logic                 w_tmr_load;
  logic [c_TIMER_W-1:0] w_tmr_load_val;
  logic                 w_tmr_en;
  logic                 w_tmr_zero;

  // Request classification: x & (x-1) clears the lowest set bit, so the
  // result is zero exactly when at most one bit is set.
  logic w_req_any;
  logic w_req_onehot;
  logic w_req_multi;

  assign w_req_any    = |vote_req;
  assign w_req_onehot = w_req_any && ((vote_req & (vote_req - NUM_CAND'(1))) == '0);
  assign w_req_multi  = w_req_any && !w_req_onehot;

  // Only an armed ballot in voting mode reacts to presses; mode has priority.
  logic w_armed_live;
  assign w_armed_live = (r_state == ST_ARMED) && !mode;

  logic                w_accept;
  logic [NUM_CAND-1:0] w_grant_nxt;
  logic                w_armed_nxt;
  logic                w_conflict_nxt;
  logic                w_timeout_nxt;
  logic [NUM_CAND-1:0] w_last_nxt;
  logic [COUNT_W-1:0]  w_count_nxt;

  logic [NUM_CAND-1:0] r_grant;
  logic                r_accepted;
  logic                r_armed;
  logic                r_conflict;
  logic                r_timeout;
  logic [NUM_CAND-1:0] r_last;
  logic [COUNT_W-1:0]  r_count;

  session_timer #(
    .WIDTH (c_TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_enable   (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and timer control.
  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = '0;
    w_tmr_en       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mode) begin
          w_state_nxt = ST_LOCKED;
        end else if (voter_enable) begin
          w_state_nxt    = ST_ARMED;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = c_TIMEOUT_LOAD;
        end
      end
      ST_ARMED: begin
        if (mode) begin
          w_state_nxt = ST_LOCKED;
        end else if (w_req_onehot) begin
          // A valid press beats an expiring timer in the same cycle.
          w_state_nxt = ST_GRANT;
        end else if (w_req_multi) begin
          // Rejected press does not pause the timeout; the timer saturates
          // at zero so the timeout fires on the next quiet cycle.
          w_tmr_en = 1'b1;
        end else if (w_tmr_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_GRANT: begin
        w_state_nxt    = ST_HOLD;
        w_tmr_load     = 1'b1;
        w_tmr_load_val = c_CONFIRM_LOAD;
      end
      ST_HOLD: begin
        if (w_tmr_zero) begin
          w_state_nxt = mode ? ST_LOCKED : ST_IDLE;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!mode) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output next values; registered below so every output comes from a flop.
  always_comb begin
    w_accept       = w_armed_live && w_req_onehot;
    w_grant_nxt    = w_accept ? vote_req : '0;
    w_armed_nxt    = (w_state_nxt == ST_ARMED);
    w_conflict_nxt = w_armed_live && w_req_multi;
    w_timeout_nxt  = w_armed_live && !w_req_any && w_tmr_zero;
    w_last_nxt     = w_accept ? vote_req : r_last;
    w_count_nxt    = r_count;
    if (w_accept && (r_count != '1)) begin
      w_count_nxt = r_count + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant    <= '0;
      r_accepted <= 1'b0;
      r_armed    <= 1'b0;
      r_conflict <= 1'b0;
      r_timeout  <= 1'b0;
      r_last     <= '0;
      r_count    <= '0;
    end else begin
      r_grant    <= w_grant_nxt;
      r_accepted <= w_accept;
      r_armed    <= w_armed_nxt;
      r_conflict <= w_conflict_nxt;
      r_timeout  <= w_timeout_nxt;
      r_last     <= w_last_nxt;
      r_count    <= w_count_nxt;
    end
  end

  assign vote_grant    = r_grant;
  assign vote_accepted = r_accepted;
  assign ballot_armed  = r_armed;
  assign conflict      = r_conflict;
  assign timeout       = r_timeout;
  assign last_choice   = r_last;
  assign ballots_cast  = r_count;

endmodule : ballot_session_ctrl
`default_nettype wire

// File: tb/tb_ballot_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ballot_session_ctrl
// Purpose  : Directed self-checking bench for ballot_session_ctrl with the
//            default parameters (4 candidates, 1000-cycle timeout, 8-cycle
//            confirmation hold). Inputs change 1 ns after a rising edge and
//            outputs are checked there, reflecting the inputs sampled on it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ballot_session_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b0;
  logic       voter_enable = 1'b0;
  logic [3:0] vote_req = 4'b0;
  logic [3:0] vote_grant;
  logic       ballot_armed;
  logic       vote_accepted;
  logic       conflict;
  logic       timeout;
  logic [3:0] last_choice;
  logic [7:0] ballots_cast;

  int total = 0;
  int bad   = 0;

  // Packed view of the pulse/flag outputs: {grant, accepted, armed, conflict, timeout}.
  logic [7:0] flags;
  assign flags = {vote_grant, vote_accepted, ballot_armed, conflict, timeout};

  ballot_session_ctrl #(
    .NUM_CAND    (4),
    .TIMEOUT_CYC (1000),
    .CONFIRM_CYC (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mode          (mode),
    .voter_enable  (voter_enable),
    .vote_req      (vote_req),
    .vote_grant    (vote_grant),
    .ballot_armed  (ballot_armed),
    .vote_accepted (vote_accepted),
    .conflict      (conflict),
    .timeout       (timeout),
    .last_choice   (last_choice),
    .ballots_cast  (ballots_cast)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mode = 1'b0; voter_enable = 1'b0; vote_req = 4'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({flags, last_choice, ballots_cast} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 00000", {flags, last_choice, ballots_cast});
    end
    tick();
    total++;
    if ({flags, last_choice, ballots_cast} !== 20'h0) begin
      bad++;
      $display("FAIL reset_idle: got %h want 00000", {flags, last_choice, ballots_cast});
    end
  endtask

  // Basic session, then presses and enables during HOLD are ignored and the
  // hold lasts exactly 8 cycles.
  task automatic test_basic_session();
    do_reset();
    vote_req = 4'b0001; tick(); vote_req = 4'b0;
    total++;
    if ({flags, ballots_cast} !== 16'h0) begin
      bad++;
      $display("FAIL no_enable_press: got %h want 0000", {flags, ballots_cast});
    end
    voter_enable = 1'b1; tick(); voter_enable = 1'b0;
    total++;
    if (flags !== 8'b0000_0_1_0_0) begin
      bad++;
      $display("FAIL armed_after_enable: got %b want 00000100", flags);
    end
    repeat (5) tick();
    vote_req = 4'b0010; tick(); vote_req = 4'b0;
    total++;
    if ({flags, last_choice, ballots_cast} !== {8'b0010_1_0_0_0, 4'b0010, 8'd1}) begin
      bad++;
      $display("FAIL grant_0010: got %h want %h", {flags, last_choice, ballots_cast},
               {8'b0010_1_0_0_0, 4'b0010, 8'd1});
    end
    tick();
    total++;
    if (flags !== 8'h0) begin
      bad++;
      $display("FAIL grant_one_cycle: got %b want 00000000", flags);
    end
    // Now in the first HOLD cycle; drive enable and a press through all 8.
    voter_enable = 1'b1; vote_req = 4'b1000;
    repeat (8) tick();
    total++;
    if ({flags, last_choice, ballots_cast} !== {8'h0, 4'b0010, 8'd1}) begin
      bad++;
      $display("FAIL hold_ignores_inputs: got %h want %h", {flags, last_choice, ballots_cast},
               {8'h0, 4'b0010, 8'd1});
    end
    // Back in IDLE: the enable is honoured, the press is not.
    tick();
    voter_enable = 1'b0; vote_req = 4'b0;
    total++;
    if ({flags, ballots_cast} !== {8'b0000_0_1_0_0, 8'd1}) begin
      bad++;
      $display("FAIL rearm_after_hold: got %h want %h", {flags, ballots_cast}, {8'b0000_0_1_0_0, 8'd1});
    end
  endtask

  task automatic test_conflict();
    do_reset();
    voter_enable = 1'b1; tick(); voter_enable = 1'b0;
    vote_req = 4'b0101; tick(); vote_req = 4'b0;
    total++;
    if ({flags, ballots_cast} !== {8'b0000_0_1_1_0, 8'd0}) begin
      bad++;
      $display("FAIL conflict_pulse: got %h want %h", {flags, ballots_cast}, {8'b0000_0_1_1_0, 8'd0});
    end
    tick();
    total++;
    if (flags !== 8'b0000_0_1_0_0) begin
      bad++;
      $display("FAIL conflict_one_cycle: got %b want 00000100", flags);
    end
    vote_req = 4'b0100; tick(); vote_req = 4'b0;
    total++;
    if ({flags, last_choice, ballots_cast} !== {8'b0100_1_0_0_0, 4'b0100, 8'd1}) begin
      bad++;
      $display("FAIL grant_after_conflict: got %h want %h", {flags, last_choice, ballots_cast},
               {8'b0100_1_0_0_0, 4'b0100, 8'd1});
    end
    tick();
    total++;
    if ({flags, ballots_cast} !== {8'h0, 8'd1}) begin
      bad++;
      $display("FAIL single_count: got %h want %h", {flags, ballots_cast}, {8'h0, 8'd1});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    voter_enable = 1'b1; tick(); voter_enable = 1'b0;
    // First armed cycle has timer 999; the timer is 0 in the 1000th.
    repeat (999) tick();
    total++;
    if (flags !== 8'b0000_0_1_0_0) begin
      bad++;
      $display("FAIL before_timeout: got %b want 00000100", flags);
    end
    tick();
    total++;
    if (flags !== 8'b0000_0_0_0_1) begin
      bad++;
      $display("FAIL timeout_pulse: got %b want 00000001", flags);
    end
    tick();
    total++;
    if (flags !== 8'h0) begin
      bad++;
      $display("FAIL timeout_one_cycle: got %b want 00000000", flags);
    end
    vote_req = 4'b0001; tick(); vote_req = 4'b0;
    total++;
    if ({flags, ballots_cast} !== 16'h0) begin
      bad++;
      $display("FAIL press_after_timeout: got %h want 0000", {flags, ballots_cast});
    end
    // A press on the cycle the timer reads 0 still wins.
    voter_enable = 1'b1; tick(); voter_enable = 1'b0;
    repeat (999) tick();
    vote_req = 4'b1000; tick(); vote_req = 4'b0;
    total++;
    if ({flags, ballots_cast} !== {8'b1000_1_0_0_0, 8'd1}) begin
      bad++;
      $display("FAIL press_at_zero: got %h want %h", {flags, ballots_cast}, {8'b1000_1_0_0_0, 8'd1});
    end
  endtask

  task automatic test_lock();
    do_reset();
    voter_enable = 1'b1; tick(); voter_enable = 1'b0;
    mode = 1'b1; vote_req = 4'b0001; tick();
    total++;
    if ({flags, ballots_cast} !== 16'h0) begin
      bad++;
      $display("FAIL lock_from_armed: got %h want 0000", {flags, ballots_cast});
    end
    voter_enable = 1'b1;
    repeat (3) tick();
    total++;
    if ({flags, ballots_cast} !== 16'h0) begin
      bad++;
      $display("FAIL locked_ignores: got %h want 0000", {flags, ballots_cast});
    end
    // Leaving LOCKED with enable held: the enable in that cycle is dropped.
    vote_req = 4'b0; mode = 1'b0; tick();
    total++;
    if (flags !== 8'h0) begin
      bad++;
      $display("FAIL unlock_no_arm: got %b want 00000000", flags);
    end
    tick(); voter_enable = 1'b0;
    total++;
    if (flags !== 8'b0000_0_1_0_0) begin
      bad++;
      $display("FAIL arm_after_unlock: got %b want 00000100", flags);
    end
    vote_req = 4'b0001; tick(); vote_req = 4'b0;
    total++;
    if ({flags, last_choice, ballots_cast} !== {8'b0001_1_0_0_0, 4'b0001, 8'd1}) begin
      bad++;
      $display("FAIL grant_after_unlock: got %h want %h", {flags, last_choice, ballots_cast},
               {8'b0001_1_0_0_0, 4'b0001, 8'd1});
    end
    // In IDLE, mode beats a simultaneous enable.
    do_reset();
    mode = 1'b1; voter_enable = 1'b1; tick(); voter_enable = 1'b0; mode = 1'b0;
    total++;
    if (flags !== 8'h0) begin
      bad++;
      $display("FAIL mode_beats_enable: got %b want 00000000", flags);
    end
  endtask

  task automatic test_saturate_and_reset();
    logic [3:0] cand;
    logic [7:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cand = 4'b0001 << (i % 4);
      exp_cnt = (i >= 254) ? 8'd255 : 8'(i + 1);
      voter_enable = 1'b1; tick(); voter_enable = 1'b0;
      vote_req = cand; tick(); vote_req = 4'b0;
      total++;
      if ({vote_grant, ballots_cast} !== {cand, exp_cnt}) begin
        bad++;
        $display("FAIL session_%0d: got grant=%b count=%0d want grant=%b count=%0d",
                 i, vote_grant, ballots_cast, cand, exp_cnt);
      end
      repeat (9) tick();
    end
    total++;
    if ({last_choice, ballots_cast} !== {4'b1000, 8'd255}) begin
      bad++;
      $display("FAIL saturated: got %h want %h", {last_choice, ballots_cast}, {4'b1000, 8'd255});
    end
    voter_enable = 1'b1; tick(); voter_enable = 1'b0;
    vote_req = 4'b0010; tick(); vote_req = 4'b0;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    total++;
    if ({flags, last_choice, ballots_cast} !== 20'h0) begin
      bad++;
      $display("FAIL reset_mid_hold: got %h want 00000", {flags, last_choice, ballots_cast});
    end
  endtask

  initial begin
    test_reset();
    test_basic_session();
    test_conflict();
    test_timeout();
    test_lock();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ballot_session_ctrl
`default_nettype wire

// File: doc/ballot_session_ctrl.md
Name: ballot_session_ctrl

Overview:
- Per-voter session sequencer between the four button debouncers and the vote logger.
- Arms one ballot per officer enable, arbitrates the candidate request pulses and forwards exactly one accepted vote per session as a one-hot grant.
- Rejects simultaneous presses, times out abandoned ballots and locks all voting while result mode is selected.

Parameters:
- NUM_CAND, 4, number of candidate request/grant lines.
- TIMEOUT_CYC, 1000, cycles an armed ballot waits for a press before it is abandoned (≥2).
- CONFIRM_CYC, 8, cycles the confirmation hold lasts after an accepted vote (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = voting, 1 = result display.
- voter_enable  in  1  officer pulse that arms a ballot.
- vote_req  in  NUM_CAND  one-cycle valid pulses from the button debouncers.
- vote_grant  out  NUM_CAND  registered one-hot, one-cycle pulse to the vote logger.
- ballot_armed  out  1  high while the ballot accepts a press.
- vote_accepted  out  1  one-cycle pulse, coincident with vote_grant.
- conflict  out  1  one-cycle pulse: more than one request bit sampled while armed.
- timeout  out  1  one-cycle pulse: armed ballot abandoned.
- last_choice  out  NUM_CAND  one-hot of the last accepted candidate; held until the next acceptance.
- ballots_cast  out  8  accepted-ballot count, saturating at 255.

Behaviour:
- Single clock domain, all state on rising clk. Reset is synchronous, active-high.
- On reset: state IDLE; every output 0; timer 0.
- All outputs are registered.
- States: IDLE, ARMED, GRANT, HOLD, LOCKED.
- IDLE:
  - vote_req is ignored.
  - mode=1 -> LOCKED; this has priority over voter_enable.
  - voter_enable=1 with mode=0 -> ARMED; timer loads TIMEOUT_CYC-1.
- ARMED: ballot_armed=1. Priority order, checked each cycle:
  - mode=1 -> LOCKED (ballot abandoned; no pulse).
  - Exactly one vote_req bit set -> latch that bit, go to GRANT.
  - More than one vote_req bit set -> conflict=1 for one cycle; stay ARMED; timer keeps running; the voter must press again.
  - Timer = 0 -> timeout=1 for one cycle, go to IDLE.
  - Otherwise decrement the timer.
  - A valid press and timer = 0 in the same cycle: the press wins.
  - voter_enable is ignored (no re-arm, no timer reload).
- GRANT (exactly 1 cycle):
  - vote_grant = latched one-hot; vote_accepted=1; last_choice updated.
  - ballots_cast increments, holding at 255.
  - Next state HOLD with timer = CONFIRM_CYC-1.
  - Latency: request sampled in cycle N -> grant visible in cycle N+1.
  - A mode change in this cycle does not cancel the grant.
- HOLD:
  - Every input is ignored until the timer reaches 0.
  - Then mode=1 -> LOCKED, otherwise -> IDLE.
- LOCKED:
  - vote_req and voter_enable are ignored.
  - mode=0 -> IDLE.
  - A voter_enable in the same cycle as that transition is not honoured.
- vote_grant is never asserted outside GRANT and never has more than one bit set.
- Timer width: $clog2(max(TIMEOUT_CYC, CONFIRM_CYC)); it is shared by ARMED and HOLD.
- Reset mid-session: an in-flight grant is discarded, ballots_cast and last_choice clear, state returns to IDLE.

Decomposition:
- Shared package voting_pkg holds:
  - the session state enum;
  - NUM_CAND_DEF=4;
  - the count width constant (8), also used by the vote logger.
- One natural sub-module, session_timer: loadable down-counter with load value, enable, and a zero flag.
- The one-hot/popcount check stays inline.

Test Plan:
- Reset, voter_enable, then vote_req=0010 after 5 cycles -> vote_grant=0010 for one cycle on the next edge, vote_accepted=1, ballots_cast=1, last_choice=0010; state returns to IDLE after 8 HOLD cycles.
- vote_req pulses with no prior voter_enable, and again during HOLD -> no grant, ballots_cast unchanged.
- Armed, vote_req=0101 -> conflict pulse, no grant; then vote_req=0100 -> grant 0100; ballots_cast +1 only once.
- Armed, no press for 1000 cycles -> timeout pulse in cycle 1000, ballot_armed falls; a later press with no new enable is ignored.
- mode=1 while armed -> LOCKED with no grant; voter_enable ignored; mode=0 then enable plus press -> normal grant.
- 256 complete sessions -> ballots_cast saturates at 255; then reset mid-HOLD -> all outputs 0 on the next cycle.
